chunk_serial_adder: RTL and testbench
=====================================

Name: chunk_serial_adder

Overview:
- Multi-cycle, parametrised two's-complement add/subtract unit for the ALU datapath.
- Processes a WIDTH-bit operand pair CHUNK bits per cycle, using a CHUNK-bit ripple adder slice with a registered carry between chunks.
- Trades latency for area relative to a full-width ripple adder.
- Uses a valid/ready handshake on both input and output, and reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits added per cycle. WIDTH must be an integer multiple of CHUNK. NCH = WIDTH/CHUNK; NCH=1 is legal.

Ports:
- clock  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and mode valid.
- in_ready  out  1  block can accept operands.
- data_a  in  WIDTH  operand A.
- data_b  in  WIDTH  operand B.
- sub  in  1  0 = A+B; 1 = A-B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset: asserting reset_n low asynchronously forces:
  - state IDLE;
  - result, carry_out, overflow, zero, out_valid = 0;
  - internal operand, carry and chunk-counter registers = 0.
  - Reset applied mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- in_ready = (state == IDLE); it is purely combinational from state. While reset is held, state is IDLE, but no capture occurs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with in_valid && in_ready, capture A, B' = B ^ {WIDTH{sub}}, carry = sub and count = 0, then go to RUN.
  - Otherwise remain in IDLE; out_valid = 0.
- RUN:
  - Each cycle, chunk i = count (LSB chunk first) computes {c, s} = A[i] + B'[i] + carry.
  - s is written into result chunk i; carry <= c; count increments.
  - On the cycle count == NCH-1:
    - carry_out <= c;
    - overflow <= (A_msb == B'_msb) && (s_msb != A_msb);
    - zero <= (full assembled result == 0);
    - go to DONE.
  - in_valid is ignored throughout RUN.
- DONE:
  - out_valid = 1; result and flags are held stable.
  - On a rising edge with out_ready, go to IDLE.
  - out_ready low stalls indefinitely with outputs stable.
- Latency: out_valid rises exactly NCH cycles after the accepting edge. Minimum initiation interval is NCH+2 cycles, because in_ready is only high in IDLE.
- After the output handshake, result and flags keep their last values while out_valid = 0. They are not valid for sampling until the next out_valid.
- The result register is updated chunk-by-chunk during RUN. Intermediate values are visible on result but meaningless while out_valid = 0.
- Inputs data_a, data_b and sub are sampled only at the accepting edge; later changes have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; the flags give the signed interpretation. Subtraction is A + ~B + 1.
- Single-cycle case NCH=1: RUN lasts one cycle. The same state sequence applies; out_valid rises 1 cycle after acceptance.

Test Plan (WIDTH=32, CHUNK=8, NCH=4):
- Add, inter-chunk carry: A=0x000000FF, B=0x00000001, sub=0 -> result=0x00000100, carry_out=0, overflow=0, zero=0; out_valid rises 4 cycles after the accepting edge.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, sub=0 -> result=0x80000000, overflow=1, carry_out=0. Also A=0x80000000, B=0x80000000 -> result=0, carry_out=1, overflow=1, zero=1.
- Full carry ripple: A=0xFFFFFFFF, B=0x00000001, sub=0 -> result=0x00000000, carry_out=1, overflow=0, zero=1.
- Subtract: A=5, B=5, sub=1 -> result=0, zero=1, carry_out=1, overflow=0. Then A=0, B=1, sub=1 -> result=0xFFFFFFFF, carry_out=0, overflow=0. Then A=0x80000000, B=1, sub=1 -> result=0x7FFFFFFF, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, result and flags stable, in_ready=0.
  - A new in_valid with different operands during this time is not captured.
  - On out_ready=1, the FSM returns to IDLE next edge; the pending in_valid is then accepted.
- Reset mid-operation: assert reset_n=0 two cycles into RUN -> result, flags and out_valid go to 0 immediately, without waiting for a clock edge.
  - After release, in_ready=1.
  - A fresh A=3, B=4 add returns 7 with correct 4-cycle latency and no residue from the aborted operation.

Source files
------------

// File: rtl/chunk_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_serial_adder
// Brief    : Multi-cycle two's-complement add/subtract. A WIDTH-bit operand
//            pair is summed CHUNK bits per cycle through one CHUNK-bit ripple
//            slice, and the carry is registered between chunks. Valid/ready
//            handshakes on both sides. Reports carry, signed overflow and
//            zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  // WIDTH must be an integer multiple of CHUNK.
  localparam int NCH = WIDTH / CHUNK;
  // The counter is kept at least one bit wide so the single-chunk case stays legal.
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;       // B already conditioned for subtract
  logic             carry_q,     carry_d;
  logic [CW-1:0]    count_q,     count_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;
  logic             zero_q,      zero_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;              // {carry, sum} of the current slice

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  // Select the operand chunk addressed by the counter and add it through the shared slice.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCH; i++) begin
      if (count_q == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    count_d     = count_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
          a_d     = data_a;
          b_d     = data_b ^ {WIDTH{sub}};
          carry_d = sub;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NCH; i++) begin
          if (count_q == CW'(i)) begin
            result_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
          end
        end
        carry_d = chunk_sum[CHUNK];
        if (count_q == LAST_CNT) begin
          // The final slice carries the MSB, so flags are resolved from it directly.
          carry_out_d = chunk_sum[CHUNK];
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
          zero_d      = (result_d == '0);
          state_d     = S_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chunk_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunk_serial_adder
// Brief    : Directed bench for chunk_serial_adder (WIDTH=32, CHUNK=8), with a
//            scoreboard of expected results fed from a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunk_serial_adder;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  exp_t sb[$];
  exp_t cur;
  int   total;
  int   passed;

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: full-width add of A and the conditioned B, flags from their definitions.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t             e;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   t;
    bb  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, s};
    e.r = t[WIDTH-1:0];
    e.c = t[WIDTH];
    e.v = (a[WIDTH-1] == bb[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present operands and hold them until accepted; the expected result is queued at acceptance.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    int n;
    data_a   = a;
    data_b   = b;
    sub      = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      @(posedge clock);
      sb.push_back(model(a, b, s));
      #1;
      in_valid = 1'b0;
      check("accept_drops_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Count cycles from the accepting edge to out_valid and check the latency.
  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    check({tag, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, NCH);
  endtask

  // Compare presented result and flags against the head of the scoreboard.
  task automatic check_out(input string tag);
    check({tag, "_sb_nonempty"}, {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check({tag, "_result"},    result,               cur.r);
      check({tag, "_carry_out"}, {31'd0, carry_out},   {31'd0, cur.c});
      check({tag, "_overflow"},  {31'd0, overflow},    {31'd0, cur.v});
      check({tag, "_zero"},      {31'd0, zero},        {31'd0, cur.z});
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"},    {31'd0, in_ready},  32'd1);
  endtask

  task automatic full_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic s);
    start_op(a, b, s);
    wait_valid(tag);
    check_out(tag);
    handshake(tag);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_a    = '0;
    data_b    = '0;
    sub       = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_result",    result,             32'd0);
    check("rst_flags",     {29'd0, carry_out, overflow, zero}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Additions: inter-chunk carry and signed overflow cases
    full_op("add_ff_1",     32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("add_ff_1_literal", result, 32'h0000_0100);
    full_op("add_7fff_1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    full_op("add_8000_8000", 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Reset two cycles into RUN: outputs clear without a clock edge
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_result",    result,             32'd0);
    check("midrst_flags",     {29'd0, carry_out, overflow, zero}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    full_op("post_rst_3_4", 32'd3, 32'd4, 1'b0);
    check("post_rst_literal", result, 32'd7);

    // Full carry ripple and subtractions
    full_op("add_ffff_1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    full_op("sub_5_5",     32'd5,         32'd5,         1'b1);
    full_op("sub_0_1",     32'd0,         32'd1,         1'b1);
    check("sub_0_1_literal", result, 32'hFFFF_FFFF);
    full_op("sub_8000_1",  32'h8000_0000, 32'h0000_0001, 1'b1);
    check("sub_8000_1_literal", {result[31:0]}, 32'h7FFF_FFFF);

    // Backpressure: DONE held for 3 cycles while a new request waits
    start_op(32'h0000_1234, 32'h0000_0011, 1'b0);
    wait_valid("bp");
    data_a   = 32'hAAAA_0000;
    data_b   = 32'h0000_5555;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready",  {31'd0, in_ready},  32'd0);
      check("bp_hold_result", result,             32'h0000_1245);
    end
    check_out("bp");
    handshake("bp");
    start_op(32'hAAAA_0000, 32'h0000_5555, 1'b0);
    wait_valid("bp_pending");
    check_out("bp_pending");
    check("bp_pending_literal", result, 32'hAAAA_5555);
    handshake("bp_pending");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
